// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment controller: register map,
// CTRL bit positions and the hex-to-segment table.
package seg7_pkg;

  // Word offsets (wbs_adr_i[7:2])
  localparam logic [5:0] REG_CTRL     = 6'h00;
  localparam logic [5:0] REG_PRESCALE = 6'h01;
  localparam logic [5:0] REG_BRIGHT   = 6'h02;
  localparam logic [5:0] REG_STATUS   = 6'h03;
  localparam logic [5:0] REG_DIGIT0   = 6'h04;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_RAW    = 2;
  localparam int CTRL_IRQ_EN = 3;

  // Segment order {g,f,e,d,c,b,a}, logical 1 = segment lit
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Merge a Wishbone write into the current register image, byte by byte.
  function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment pattern (logical polarity, 1 = lit).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed NUM_DIGITS 7-segment controller with a Wishbone register
// file, PWM brightness, hex/raw modes, runtime polarity and frame interrupt.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  input  logic                  pol_in,
  output logic [7:0]            seg_out,
  output logic [7:0]            seg_oeb,
  output logic [NUM_DIGITS-1:0] dig_out,
  output logic [NUM_DIGITS-1:0] dig_oeb,
  output logic                  irq
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [3:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] bright;
  logic [7:0]            digit [NUM_DIGITS];

  logic [PRESCALE_W-1:0] cnt;
  logic [2:0]            idx;
  logic [7:0]            frame_cnt;
  logic                  pol_meta;
  logic                  pol_sync;

  logic        en;
  logic [5:0]  word;
  logic        hit;
  logic        req;
  logic [31:0] rd_data;
  logic [31:0] wr_word;

  assign en   = ctrl[CTRL_EN];
  assign word = wbs_adr_i[7:2];
  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A new request is only taken while ack is low, so transfers pair up.
  assign req  = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (word)
      REG_CTRL:     rd_data = {28'h0, ctrl};
      REG_PRESCALE: rd_data = 32'(prescale);
      REG_BRIGHT:   rd_data = 32'(bright);
      REG_STATUS:   rd_data = {16'h0, frame_cnt, 5'h0, idx};
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (word == REG_DIGIT0 + 6'(i)) rd_data = {24'h0, digit[i]};
        end
      end
    endcase
  end

  // The current value of the addressed register is the base for byte merging.
  assign wr_word = apply_sel(rd_data, wbs_dat_i, wbs_sel_i);

  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wr_word};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;
    end
  end

  // NOTE: the digit store is a handful of flops that must read 0 after reset,
  // so it is reset like any other register rather than treated as a RAM.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ctrl     <= '0;
      prescale <= '0;
      bright   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
    end else if (req && wbs_we_i) begin
      case (word)
        REG_CTRL:     ctrl     <= wr_word[3:0];
        REG_PRESCALE: prescale <= wr_word[PRESCALE_W-1:0];
        REG_BRIGHT:   bright   <= wr_word[PRESCALE_W-1:0];
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word == REG_DIGIT0 + 6'(i)) digit[i] <= wr_word[7:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      pol_meta <= 1'b0;
      pol_sync <= 1'b0;
    end else begin
      pol_meta <= pol_in;
      pol_sync <= pol_meta;
    end
  end

  logic slot_end;
  logic frame_end;

  // >= rather than == so shrinking PRESCALE mid-slot still ends the slot.
  assign slot_end  = (cnt >= prescale);
  assign frame_end = slot_end && (idx == LAST_IDX);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cnt       <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      irq <= en && ctrl[CTRL_IRQ_EN] && frame_end;
      if (!en) begin
        cnt <= '0;
        idx <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        if (frame_end) begin
          idx       <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        cnt <= cnt + PRESCALE_W'(1);
      end
    end
  end

  logic [7:0]            cur_digit;
  logic [6:0]            hex_seg;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  lit;
  logic                  act;
  logic [7:0]            pattern;

  always_comb begin
    cur_digit = '0;
    dig_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_digit  = digit[i];
        dig_sel[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_hex (
    .nibble (cur_digit[3:0]),
    .seg    (hex_seg)
  );

  assign lit     = en && (cnt < bright);
  assign act     = pol_sync ^ ctrl[CTRL_INV];
  assign pattern = lit ? {cur_digit[7], ctrl[CTRL_RAW] ? cur_digit[6:0] : hex_seg}
                       : 8'h00;

  // Reset level 8'hFF is the inactive level for the post-reset polarity (act = 0).
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      seg_out <= 8'hFF;
      dig_out <= '0;
      seg_oeb <= 8'hFF;
      dig_oeb <= '1;
    end else begin
      seg_out <= act ? pattern : ~pattern;
      dig_out <= lit ? dig_sel : '0;
      seg_oeb <= {8{~en}};
      dig_oeb <= {NUM_DIGITS{~en}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed and randomized scans
// compared against a cycle-count based reference model.
module tb_seg7_scan_ctrl;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        pol_in;
  logic [7:0]  seg_out, seg_oeb;
  logic [N-1:0] dig_out, dig_oeb;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tb_digit [N];
  logic [6:0] hex_ref [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE_W(16), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_dat_o (rdat),
    .wbs_ack_o (ack),
    .pol_in    (pol_in),
    .seg_out   (seg_out),
    .seg_oeb   (seg_oeb),
    .dig_out   (dig_out),
    .dig_oeb   (dig_oeb),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    adr = a; wdat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    check("wr_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    check("rd_ack", 32'(ack), 32'd1);
    d = rdat;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic set_digit(input int i, input logic [7:0] d);
    wb_write(BASE + 32'h10 + 32'(4 * i), {24'h0, d}, 4'hF);
    tb_digit[i] = d;
  endtask

  // Reference: sample k after the enabling edge shows scan time t = k-1.
  task automatic run_scan(input int p, input int b, input bit raw, input bit inv,
                          input bit pol, input bit irqen, input int k_max);
    int t, slot, di, per;
    bit act, on;
    logic [7:0] pat, exp_seg;
    logic [N-1:0] exp_dig;
    pol_in = pol;
    repeat (4) @(posedge clk);
    #1;
    wb_write(BASE + 32'h04, 32'(p), 4'hF);
    wb_write(BASE + 32'h08, 32'(b), 4'hF);
    wb_write(BASE, {28'h0, irqen, raw, inv, 1'b1}, 4'hF);
    act = pol ^ inv;
    per = N * (p + 1);
    for (int k = 1; k <= k_max; k++) begin
      @(posedge clk); #1;
      t    = k - 1;
      slot = t / (p + 1);
      di   = slot % N;
      on   = (t % (p + 1)) < b;
      pat  = on ? {tb_digit[di][7], raw ? tb_digit[di][6:0] : hex_ref[tb_digit[di][3:0]]}
                : 8'h00;
      exp_seg = act ? pat : ~pat;
      exp_dig = on ? (N'(1) << di) : '0;
      check("seg_out", 32'(seg_out), 32'(exp_seg));
      check("dig_out", 32'(dig_out), 32'(exp_dig));
      check("seg_oeb_on", 32'(seg_oeb), 32'h0);
      check("dig_oeb_on", 32'(dig_oeb), 32'h0);
      check("irq", 32'(irq), 32'(irqen && (k % per == 0)));
    end
    wb_write(BASE, {28'h0, irqen, raw, inv, 1'b0}, 4'hF);
    @(posedge clk); #1;
    check("off_dig", 32'(dig_out), 32'h0);
    check("off_seg", 32'(seg_out), act ? 32'h00 : 32'hFF);
    check("off_seg_oeb", 32'(seg_oeb), 32'hFF);
    check("off_dig_oeb", 32'(dig_oeb), 32'(4'hF));
  endtask

  initial begin
    logic [31:0] rd;
    bit seen;
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; wdat = '0; pol_in = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) tb_digit[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_seg", 32'(seg_out), 32'hFF);
    check("rst_dig", 32'(dig_out), 32'h0);
    check("rst_seg_oeb", 32'(seg_oeb), 32'hFF);
    check("rst_dig_oeb", 32'(dig_oeb), 32'(4'hF));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Register file: byte selects, unmapped read, address miss
    wb_write(BASE + 32'h04, 32'h0000_1234, 4'b0001);
    wb_read(BASE + 32'h04, rd);
    check("prescale_sel", rd, 32'h0000_0034);
    wb_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h20, rd);
    check("unmapped_rd", rd, 32'h0);
    adr = BASE + 32'h100; we = 1'b0; cyc = 1'b1; stb = 1'b1; seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    check("miss_no_ack", 32'(seen), 32'h0);

    // Directed scans: hex digits, PWM, blank, polarity
    for (int i = 0; i < N; i++) set_digit(i, 8'(i));
    run_scan(3, 4, 0, 0, 1, 0, 40);
    run_scan(7, 2, 0, 0, 1, 0, 40);
    run_scan(7, 0, 0, 0, 1, 0, 20);
    set_digit(0, 8'h08);
    run_scan(3, 8, 0, 0, 0, 0, 16);
    run_scan(3, 8, 0, 1, 0, 0, 16);

    // Raw mode and byte-lane honouring on DIGIT1
    wb_write(BASE + 32'h14, 32'h0000_00A5, 4'b0001);
    tb_digit[1] = 8'hA5;
    wb_write(BASE + 32'h14, 32'h0000_0033, 4'b0010);
    wb_read(BASE + 32'h14, rd);
    check("digit1_sel", rd, 32'h0000_00A5);
    run_scan(2, 5, 1, 0, 1, 0, 24);

    // Randomized configurations
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < N; i++) set_digit(i, 8'($urandom_range(0, 255)));
      run_scan(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 30);
    end

    // Reset during a read ack cycle
    wb_write(BASE, 32'h1, 4'hF);
    @(posedge clk); #1;
    check("pre_rst_oeb", 32'(seg_oeb), 32'h0);
    adr = BASE + 32'h10; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(ack), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_seg_oeb", 32'(seg_oeb), 32'hFF);
    check("mid_rst_dig_oeb", 32'(dig_oeb), 32'(4'hF));
    check("mid_rst_dig", 32'(dig_out), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < N; i++) tb_digit[i] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wb_read(BASE + 32'h0C, rd);
    check("post_rst_status", rd, 32'h0);
    wb_read(BASE, rd);
    check("post_rst_ctrl", rd, 32'h0);
    wb_read(BASE + 32'h10, rd);
    check("post_rst_digit0", rd, 32'h0);

    // Frame interrupt with 1-cycle slots; frame count passes 255 -> 0
    run_scan(0, 1, 0, 0, 1, 1, 1027);
    wb_read(BASE + 32'h0C, rd);
    check("status_frames", rd, {16'h0, 8'(((1027 + 1) / N) % 256), 8'h00});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display controller with a Wishbone slave register file.
- Generalises the single fixed-digit output to NUM_DIGITS scanned digits.
- Adds programmable scan rate, PWM brightness, hex/raw modes, runtime polarity and a frame interrupt.
- Sits inside the user project and drives segment and digit-select pads through the io_out/io_oeb ranges.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (1..8).
- PRESCALE_W, 16, width of the slot-length and brightness counters.
- BASE_ADDR, 32'h3000_0000, Wishbone base; block decodes wbs_adr_i[31:8] == BASE_ADDR[31:8].

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous, active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- pol_in  in  1  board polarity pin; 1 = active-high segments
- seg_out  out  8  {dp,g..a} segment drive
- seg_oeb  out  8  segment pad output-enable-bar
- dig_out  out  NUM_DIGITS  one-hot digit select
- dig_oeb  out  NUM_DIGITS  digit pad output-enable-bar
- irq  out  1  frame-complete pulse

Behaviour:
- Reset (wb_rst_i=0, async):
  - all registers 0; scan index 0, prescaler 0
  - wbs_ack_o=0, wbs_dat_o=0, irq=0
  - seg_out = all inactive level, dig_out = 0
  - seg_oeb and dig_oeb all 1 (pads high-Z)
  - Reset mid-transaction drops ack; the master retries.
- Register map (word offset = adr[7:2]):
  - 0x00 CTRL: [0] en, [1] inv, [2] raw, [3] irq_en
  - 0x04 PRESCALE [PRESCALE_W-1:0]
  - 0x08 BRIGHT [PRESCALE_W-1:0]
  - 0x0C STATUS (RO): [2:0] current index, [15:8] frame count mod 256
  - 0x10+4*i DIGIT[i] [7:0], i < NUM_DIGITS
  - Unmapped or out-of-range reads return 0; writes to them are ignored.
  - Writes honour wbs_sel_i per byte.
- Wishbone handshake:
  - When cyc&stb&hit and ack=0: ack=1 next cycle for exactly one cycle.
  - Read data is valid in that ack cycle.
  - Write takes effect on the same edge ack rises.
  - Back-to-back transactions give ack every other cycle.
  - No ack on an address miss.
- Scan:
  - When en=1, the prescaler counts 0..PRESCALE, then wraps to 0 and increments the index.
  - Index wraps NUM_DIGITS-1 -> 0.
  - On the index wrap, frame count increments and irq pulses for 1 cycle if irq_en.
  - PRESCALE=0 gives a 1-cycle slot.
  - A PRESCALE write takes effect at the next wrap; a smaller value never traps the counter (compare with >=).
- Outputs, registered, 1 cycle after the index/count change:
  - dig_out one-hot at index, gated by PWM.
  - PWM on iff prescaler < BRIGHT. BRIGHT=0 blanks; BRIGHT > PRESCALE gives full on.
  - Segments: raw=1 uses DIGIT[i][6:0]; raw=0 uses the hex decode of DIGIT[i][3:0] (0-F standard patterns). dp = DIGIT[i][7].
  - Active level = pol_in ^ inv. Inactive/blanked segments drive the inverse level. dig_out active-high.
- When en=0:
  - counters hold at 0, index 0, outputs blanked
  - seg_oeb/dig_oeb = 0 whenever en=1, else 1
  - Clearing en mid-slot blanks on the next cycle.
- Simultaneous Wishbone write to DIGIT[i] while i is displayed: the new value appears from the next cycle.
- pol_in is double-flop synchronised before use.

Decomposition:
- Package seg7_pkg holds:
  - register offset constants
  - CTRL bit indices
  - the 16-entry hex-to-segment constant table
- One natural sub-module: seg7_hex_decode (combinational 4-bit -> 7-segment), instantiated once on the muxed digit value.

Test Plan:
- Reset with regs written, then wb_rst_i=0 mid-read -> ack=0, all oeb=1, STATUS reads 0 after release.
- Single-digit scan: NUM_DIGITS=4, PRESCALE=3, BRIGHT=4, en=1, DIGIT0..3=0,1,2,3 in hex mode, pol_in=1 -> dig_out cycles 0001,0010,0100,1000 every 4 cycles; seg_out 0x3F,0x06,0x5B,0x4F.
- PWM: PRESCALE=7, BRIGHT=2 -> each digit active 2 of 8 cycles; BRIGHT=0 -> dig_out stays 0.
- Polarity: pol_in=0, inv=0, DIGIT0=8 -> seg_out=0x80 (dp inactive high, segments low); set inv=1 -> 0x7F.
- Raw mode + byte select: write 0x0000_00A5 with sel=0001 to DIGIT1, raw=1 -> seg_out=0xA5 during slot 1; the same write with sel=0010 leaves DIGIT1 unchanged.
- Frame IRQ: irq_en=1, PRESCALE=0 -> irq pulses 1 cycle every 4 cycles; STATUS[15:8] increments and wraps 255->0.
